rom_arbiter_n: RTL and testbench

- Parametrised N-channel read arbiter between ROM segments and the single 32-bit SDRAM controller port.
- Adds over the fixed 3/4-ROM controller: a configurable channel count, selectable fixed or round-robin arbitration, and a pending-tag FIFO that allows several SDRAM reads in flight.
- Also packs IOCTL download bytes into 32-bit SDRAM writes.
- Sits between the segment caches and the SDRAM controller in the top level.

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/tag_fifo.sv | 62 ++++++
 rtl/rom_arbiter_n.sv | 202 ++++++++++++++++++++
 tb/tb_rom_arbiter_n.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the N-channel ROM read arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_e;

    // Returned by the grant pick when no channel is requesting.
    localparam int NONE = -1;

    // Width of a channel id; never below one bit so two-channel builds still work.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Small FIFO holding the channel id of every read that is acked but not yet returned.
module tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = inc(rd_ptr_q);
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tag storage carries no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rom_arbiter_n.sv
// N-channel ROM read arbiter onto one SDRAM port, with pipelined read tags and
// IOCTL byte-to-word packing for downloads.
module rom_arbiter_n
    import rom_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int RR_MODE    = 0,
    parameter int PEND_DEPTH = 2,
    parameter int DL_INDEX   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [DATA_W-1:0]        ch_data,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_data,
    input  logic [15:0]              ioctl_index,
    input  logic                     ioctl_wr,
    input  logic                     ioctl_download,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [31:0]              sdram_data,
    output logic                     sdram_we,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    input  logic                     sdram_valid,
    input  logic [31:0]              sdram_q,
    output logic                     err_orphan
);

    localparam int IDW = id_w(NUM_CH);

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       lane_q, lane_d;
    logic              wr_pend_q, wr_pend_d;
    logic              err_q, err_d;
    logic [31:0]       wr_word_q, wr_word_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic              fifo_push, fifo_full, fifo_empty;
    logic [IDW-1:0]    fifo_dout;
    logic              dl_active, dl_wr, dl_last;
    logic [31:0]       word_now;
    logic [ADDR_W-1:0] dl_waddr;
    int                pick_sel;
    logic [IDW-1:0]    pick_id;

    // First requesting channel scanning upward from the base, wrapping.
    function automatic int pick(input logic [NUM_CH-1:0] req, input logic [IDW-1:0] ptr);
        int base;
        int idx;
        int sel;
        base = (RR_MODE != 0) ? int'(ptr) : 0;
        sel  = NONE;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (base + k) % NUM_CH;
            if (sel == NONE && req[idx]) sel = idx;
        end
        return sel;
    endfunction

    assign pick_sel  = pick(ch_req, rr_ptr_q);
    assign pick_id   = IDW'(pick_sel);
    assign dl_active = ioctl_download && (ioctl_index == 16'(DL_INDEX));
    assign dl_wr     = dl_active && ioctl_wr;
    assign dl_last   = dl_wr && (ioctl_addr[1:0] == 2'd3);
    assign word_now  = {ioctl_data, lane_q};
    assign dl_waddr  = ADDR_W'(ioctl_addr[24:2]);

    always_comb begin
        lane_d = lane_q;
        if (dl_wr) begin
            case (ioctl_addr[1:0])
                2'd0:    lane_d[7:0]   = ioctl_data;
                2'd1:    lane_d[15:8]  = ioctl_data;
                2'd2:    lane_d[23:16] = ioctl_data;
                default: lane_d        = lane_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_pend_d = wr_pend_q;
        wr_word_d = wr_word_q;
        wr_addr_d = wr_addr_q;
        fifo_push = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Download writes win over reads; a word completed while busy waits here.
                if (dl_last || wr_pend_q) begin
                    state_d   = WR;
                    req_d     = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = dl_last ? dl_waddr : wr_addr_q;
                    wdata_d   = dl_last ? word_now : wr_word_q;
                    wr_pend_d = 1'b0;
                end else if (!ioctl_download && (|ch_req) && !fifo_full) begin
                    state_d = RD;
                    grant_d = pick_id;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ch_addr[int'(pick_id)*ADDR_W +: ADDR_W];
                end
            end
            RD: begin
                if (sdram_ack) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    fifo_push = 1'b1;
                    rr_ptr_d  = (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
                end
            end
            WR: begin
                if (sdram_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (dl_last && state_q != IDLE) begin
            wr_pend_d = 1'b1;
            wr_word_d = word_now;
            wr_addr_d = dl_waddr;
        end
    end

    assign err_d = err_q || (sdram_valid && fifo_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lane_q    <= '0;
            wr_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lane_q    <= lane_d;
            wr_pend_q <= wr_pend_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_word_q <= wr_word_d;
        wr_addr_q <= wr_addr_d;
    end

    tag_fifo #(
        .DEPTH (PEND_DEPTH),
        .WIDTH (IDW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (sdram_valid),
        .din   (grant_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ch_ack     = (state_q == RD && sdram_ack) ? (NUM_CH'(1) << grant_q) : '0;
    assign ch_valid   = (sdram_valid && !fifo_empty) ? (NUM_CH'(1) << fifo_dout) : '0;
    assign ch_data    = sdram_q;
    assign sdram_addr = addr_q;
    assign sdram_data = wdata_q;
    assign sdram_we   = we_q;
    assign sdram_req  = req_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_rom_arbiter_n.sv
// Bench for rom_arbiter_n: a fixed-priority and a round-robin instance driven cycle by cycle.
module tb_rom_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 23;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    a_req, a_chack, a_chvalid;
    logic [N*AW-1:0] a_addr;
    logic [31:0]     a_chdata, a_sdata, a_q;
    logic [24:0]     a_ioaddr;
    logic [7:0]      a_iodata;
    logic [15:0]     a_ioidx;
    logic            a_iowr, a_dl, a_swe, a_sreq, a_ack, a_valid, a_err;
    logic [AW-1:0]   a_saddr;

    logic [N-1:0]    b_req, b_chack, b_chvalid;
    logic [N*AW-1:0] b_addr;
    logic [31:0]     b_chdata, b_sdata, b_q;
    logic            b_swe, b_sreq, b_ack, b_valid, b_err;
    logic [AW-1:0]   b_saddr;

    rom_arbiter_n #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(32), .RR_MODE(0), .PEND_DEPTH(2), .DL_INDEX(0)) u_fix (
        .clk(clk), .reset(reset), .ch_req(a_req), .ch_addr(a_addr), .ch_ack(a_chack),
        .ch_valid(a_chvalid), .ch_data(a_chdata), .ioctl_addr(a_ioaddr), .ioctl_data(a_iodata),
        .ioctl_index(a_ioidx), .ioctl_wr(a_iowr), .ioctl_download(a_dl), .sdram_addr(a_saddr),
        .sdram_data(a_sdata), .sdram_we(a_swe), .sdram_req(a_sreq), .sdram_ack(a_ack),
        .sdram_valid(a_valid), .sdram_q(a_q), .err_orphan(a_err));

    rom_arbiter_n #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(32), .RR_MODE(1), .PEND_DEPTH(2), .DL_INDEX(0)) u_rr (
        .clk(clk), .reset(reset), .ch_req(b_req), .ch_addr(b_addr), .ch_ack(b_chack),
        .ch_valid(b_chvalid), .ch_data(b_chdata), .ioctl_addr(25'd0), .ioctl_data(8'd0),
        .ioctl_index(16'd0), .ioctl_wr(1'b0), .ioctl_download(1'b0), .sdram_addr(b_saddr),
        .sdram_data(b_sdata), .sdram_we(b_swe), .sdram_req(b_sreq), .sdram_ack(b_ack),
        .sdram_valid(b_valid), .sdram_q(b_q), .err_orphan(b_err));

    typedef struct {
        logic [N-1:0] req;
        int           g;
    } vec_t;

    vec_t            fv [6];
    vec_t            rv [9];
    int              n_chk = 0;
    int              n_err = 0;
    int              sb_ch[$];
    logic [31:0]     sb_d[$];
    logic [AW-1:0]   pipe[$];
    logic [7:0]      dl_bytes [4];

    function automatic logic [AW-1:0] chaddr(input int i);
        return AW'(32'h012340 + i * 32'h1111);
    endfunction

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        return {9'h0A5, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expects the DUT idle with a request visible; grants, acks, and queues the expected return.
    task automatic hs_a(input int e_ch, input int waits, input logic [N-1:0] next_req);
        nxt(); settle();
        chk("grant_req", a_sreq, 1);
        chk("grant_we", a_swe, 0);
        chk("grant_addr", a_saddr, chaddr(e_ch));
        for (int w = 0; w < waits; w++) begin
            nxt(); settle();
            chk("held_req", {a_sreq, a_saddr}, {1'b1, chaddr(e_ch)});
            chk("no_early_ack", a_chack, 0);
        end
        a_ack = 1'b1; settle();
        chk("ch_ack", a_chack, N'(1) << e_ch);
        sb_ch.push_back(e_ch);
        sb_d.push_back(mem_val(chaddr(e_ch)));
        pipe.push_back(a_saddr);
        nxt(); a_ack = 1'b0; a_req = next_req; settle();
        chk("req_drop", a_sreq, 0);
    endtask

    task automatic deliver_a();
        int          e;
        logic [31:0] d;
        a_valid = 1'b1;
        a_q = (pipe.size() > 0) ? mem_val(pipe.pop_front()) : 32'hDEAD_BEEF;
        settle();
        if (sb_ch.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_underflow: got ch_valid %0h, want no return pending", a_chvalid);
        end else begin
            e = sb_ch.pop_front();
            d = sb_d.pop_front();
            chk("ch_valid", a_chvalid, N'(1) << e);
            chk("ch_data", a_chdata, d);
        end
        nxt(); a_valid = 1'b0; a_q = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fv = '{'{4'b1010, 1}, '{4'b1111, 0}, '{4'b0100, 2}, '{4'b1100, 2}, '{4'b1000, 3}, '{4'b0011, 0}};
        rv = '{'{4'b1111, 0}, '{4'b1111, 1}, '{4'b1111, 2}, '{4'b1111, 3}, '{4'b1111, 0},
               '{4'b1001, 3}, '{4'b1001, 0}, '{4'b0101, 2}, '{4'b0011, 0}};
        dl_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1;
        a_req = '0; a_ack = 0; a_valid = 0; a_q = '0;
        a_ioaddr = '0; a_iodata = '0; a_ioidx = '0; a_iowr = 0; a_dl = 0;
        b_req = '0; b_ack = 0; b_valid = 0; b_q = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i*AW +: AW] = chaddr(i);
            b_addr[i*AW +: AW] = chaddr(i);
        end
        nxt(); nxt(); settle();
        chk("a_reset", {a_sreq, a_swe, a_saddr, a_sdata, a_err, a_chack, a_chvalid}, 0);
        chk("b_reset", {b_sreq, b_swe, b_saddr, b_sdata, b_err, b_chack, b_chvalid}, 0);
        nxt(); reset = 1'b0;

        // Fixed priority: one grant per pattern, then its data returns.
        for (int i = 0; i < 6; i++) begin
            a_req = fv[i].req;
            hs_a(fv[i].g, i % 2, '0);
            deliver_a();
        end

        // 1010: ch1 first, ch3 issued two cycles after the first ack.
        a_req = 4'b1010;
        hs_a(1, 1, 4'b1000);
        hs_a(3, 0, '0);
        deliver_a();
        deliver_a();

        // Two reads in flight fill the tag FIFO; ch3 must wait for a return.
        a_req = 4'b0101;
        hs_a(0, 0, 4'b0100);
        hs_a(2, 0, 4'b1000);
        for (int w = 0; w < 4; w++) begin
            nxt(); settle();
            chk("full_stall", a_sreq, 0);
        end
        deliver_a();
        hs_a(3, 0, '0);
        deliver_a();
        deliver_a();

        // Download packing with the enabled index.
        a_dl = 1'b1; a_ioidx = 16'd0;
        for (int k = 0; k < 4; k++) begin
            a_ioaddr = 25'h100 + 25'(k); a_iodata = dl_bytes[k]; a_iowr = 1'b1; settle();
            chk("dl_no_early_wr", a_sreq, 0);
            nxt();
        end
        a_iowr = 1'b0; settle();
        chk("dl_req_we", {a_sreq, a_swe}, 2'b11);
        chk("dl_addr", a_saddr, 23'h40);
        chk("dl_data", a_sdata, 32'h4433_2211);
        a_ack = 1'b1; settle();
        chk("dl_no_chack", a_chack, 0);
        nxt(); a_ack = 1'b0; settle();
        chk("dl_drop", {a_sreq, a_swe}, 2'b00);

        // Other index: bytes are ignored.
        a_ioidx = 16'd1;
        for (int k = 0; k < 4; k++) begin
            a_ioaddr = 25'h100 + 25'(k); a_iodata = dl_bytes[k]; a_iowr = 1'b1;
            nxt();
        end
        a_iowr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            settle();
            chk("dl_idx1_no_wr", a_sreq, 0);
            nxt();
        end

        // Download rises while a read is in RD: it completes and its data still arrives.
        a_dl = 1'b0; a_ioidx = 16'd0;
        a_req = 4'b0001;
        nxt(); settle();
        chk("dlrd_grant", {a_sreq, a_saddr}, {1'b1, chaddr(0)});
        a_dl = 1'b1; a_ack = 1'b1; settle();
        chk("dlrd_ack", a_chack, 4'b0001);
        sb_ch.push_back(0); sb_d.push_back(mem_val(chaddr(0))); pipe.push_back(a_saddr);
        nxt(); a_ack = 1'b0; a_req = 4'b0010;
        for (int w = 0; w < 3; w++) begin
            settle();
            chk("dl_blocks_rd", a_sreq, 0);
            nxt();
        end
        deliver_a();
        for (int w = 0; w < 2; w++) begin
            settle();
            chk("dl_blocks_rd2", a_sreq, 0);
            nxt();
        end
        a_dl = 1'b0;
        hs_a(1, 0, '0);
        deliver_a();

        // Orphan return, sticky error, then async reset during RD.
        a_valid = 1'b1; a_q = 32'h1234_5678; settle();
        chk("orphan_no_valid", a_chvalid, 0);
        nxt(); a_valid = 1'b0; settle();
        chk("orphan_err", a_err, 1);
        nxt(); settle();
        chk("orphan_sticky", a_err, 1);
        a_req = 4'b0001;
        nxt(); settle();
        chk("rst_rd_req", a_sreq, 1);
        reset = 1'b1; a_req = '0; settle();
        chk("rst_async_req", a_sreq, 0);
        chk("rst_async_err", a_err, 0);
        nxt(); reset = 1'b0;

        // Round-robin grant order on the second instance.
        b_req = rv[0].req;
        for (int i = 0; i < 9; i++) begin
            nxt(); settle();
            chk("rr_req", {b_sreq, b_swe}, 2'b10);
            chk("rr_addr", b_saddr, chaddr(rv[i].g));
            b_ack = 1'b1; settle();
            chk("rr_ack", b_chack, N'(1) << rv[i].g);
            nxt();
            b_ack = 1'b0; b_valid = 1'b1; b_q = 32'hB000_0000 + 32'(i);
            b_req = (i + 1 < 9) ? rv[i+1].req : '0;
            settle();
            chk("rr_valid", b_chvalid, N'(1) << rv[i].g);
            chk("rr_data", b_chdata, 32'hB000_0000 + 32'(i));
            chk("rr_gap", b_sreq, 0);
        end
        nxt(); b_valid = 1'b0;

        chk("sb_drained", sb_ch.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
